// File: rtl/sram_initiator_pkg.sv
// Shared types for the SRAM initiator: core-side and SRAM-side
// request/response bundles, FSM state encoding and timer sizing.
package sram_initiator_pkg;

    typedef logic [63:0] xlen_t;
    typedef logic [7:0]  strb_t;

    typedef struct packed {
        logic  valid;
        logic  wrOrRd;
        xlen_t addr;
        xlen_t wrDat;
        strb_t wrStrb;
    } CoreMemReq_t;

    typedef struct packed {
        logic  valid;
        xlen_t rdDat;
        logic  err;
    } CoreMemRsp_t;

    typedef struct packed {
        logic  req;
        logic  wrOrRd;
        xlen_t addr;
        xlen_t wrDat;
        strb_t wrStrb;
    } SramReq_t;

    typedef struct packed {
        logic  addrOK;
        logic  datOK;
        xlen_t rdDat;
    } SramRsp_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sram_init_state_t;

    localparam int REQ_DEPTH_DEF   = 2;
    localparam int TIMEOUT_CYC_DEF = 255;

    function automatic int tmr_width(input int cyc);
        int w;
        w = $clog2(cyc + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/sram_req_fifo.sv
// Synchronous FIFO of core requests; extra pointer MSB
// distinguishes full from empty when the indices match.
module sram_req_fifo
    import sram_initiator_pkg::*;
#(
    parameter int DEPTH = REQ_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        push,
    input  CoreMemReq_t din,
    input  logic        pop,
    output CoreMemReq_t head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wp;
    logic [AW:0] rp;
    CoreMemReq_t mem [DEPTH];

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full)
                wp <= wp + (AW+1)'(1);
            if (pop && !empty)
                rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wp[AW-1:0]] <= din;
    end

    assign head  = mem[rp[AW-1:0]];
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);

endmodule

// File: rtl/sram_initiator.sv
// Initiator end of the SRAM req/addrOK/datOK protocol: queues core
// requests, runs one SRAM transaction at a time, watchdog on stalls.
module sram_initiator
    import sram_initiator_pkg::*;
#(
    parameter int REQ_DEPTH   = REQ_DEPTH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        nRst,
    input  CoreMemReq_t iCoreReq,
    output logic        oCoreReqReady,
    output CoreMemRsp_t oCoreRsp,
    input  logic        iCoreRspReady,
    output SramReq_t    oReq,
    input  SramRsp_t    iRsp,
    output logic        oBusy
);

    localparam int TMR_W = tmr_width(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);

    sram_init_state_t state_q;
    sram_init_state_t state_d;

    logic [TMR_W-1:0] timer_q;
    logic             timeout;
    logic             active;

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    CoreMemReq_t head;

    logic  inflight_wr;
    logic  rsp_load;
    logic  rsp_err_d;
    logic  rsp_err_q;
    xlen_t rsp_dat_d;
    xlen_t rsp_dat_q;

    assign oCoreReqReady = nRst && !fifo_full;
    assign fifo_push     = iCoreReq.valid && oCoreReqReady;

    sram_req_fifo #(
        .DEPTH (REQ_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nRst  (nRst),
        .push  (fifo_push),
        .din   (iCoreReq),
        .pop   (fifo_pop),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign active  = (state_q == ISSUE) || (state_q == WAIT);
    assign timeout = (timer_q == TMR_MAX);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        rsp_load  = 1'b0;
        rsp_err_d = 1'b0;
        rsp_dat_d = '0;
        oReq      = '0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty)
                    state_d = ISSUE;
            end
            ISSUE: begin
                // stored entries always carry valid=1
                oReq.req    = head.valid;
                oReq.wrOrRd = head.wrOrRd;
                oReq.addr   = head.addr;
                if (head.wrOrRd) begin
                    oReq.wrDat  = head.wrDat;
                    oReq.wrStrb = head.wrStrb;
                end
                if (iRsp.addrOK) begin
                    fifo_pop = 1'b1;
                    state_d  = WAIT;
                end else if (timeout) begin
                    fifo_pop  = 1'b1;
                    rsp_load  = 1'b1;
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end
            end
            WAIT: begin
                if (iRsp.datOK) begin
                    rsp_load  = 1'b1;
                    rsp_dat_d = inflight_wr ? '0 : iRsp.rdDat;
                    state_d   = RESP;
                end else if (timeout) begin
                    rsp_load  = 1'b1;
                    rsp_err_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (iCoreRspReady)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // restarts on every entry into ISSUE or WAIT
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            timer_q <= '0;
        else if (!active || state_d != state_q)
            timer_q <= '0;
        else
            timer_q <= timer_q + TMR_W'(1);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            inflight_wr <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (state_q == ISSUE && iRsp.addrOK)
                inflight_wr <= head.wrOrRd;
            if (rsp_load) begin
                rsp_dat_q <= rsp_dat_d;
                rsp_err_q <= rsp_err_d;
            end
        end
    end

    always_comb begin
        oCoreRsp       = '0;
        oCoreRsp.valid = (state_q == RESP);
        oCoreRsp.rdDat = rsp_dat_q;
        oCoreRsp.err   = rsp_err_q;
    end

    assign oBusy = !fifo_empty || (state_q != IDLE);

endmodule
